number_of_1s_count: RTL and testbench
=====================================

Name: number_of_1s_count

Overview:
Registered population-count block. Counts the number of '1' bits on the input vector `data` and presents the result on `count` one clock later. It is a leaf datapath utility for status and flag aggregation. Default configuration is a 3-bit input with a 2-bit count. Width is parameterised so the same block serves wider vectors.

Parameters:
- WIDTH, 3, number of input bits to count; legal range 1..64.
- CW, $clog2(WIDTH+1), width of `count`; derived localparam, not overridable (WIDTH=3 -> CW=2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  qualifies `data` this cycle.
- data  input  WIDTH  vector whose set bits are counted.
- count  output  CW  registered number of '1' bits in the last accepted `data`.
- out_valid  output  1  high for exactly one cycle per accepted input; marks `count` as updated.
- is_zero  output  1  registered; 1 when the last accepted `data` had no set bits.
- is_all  output  1  registered; 1 when the last accepted `data` had all WIDTH bits set.

Behaviour:
- One clock domain; no combinational path from input to output. All outputs come straight from flops.
- Reset:
  - Checked only at a rising clk edge with rst_n=0.
  - count=0, out_valid=0, is_zero=1, is_all=0 (is_all=1 if WIDTH=0 is ever allowed; it is not).
  - Reset takes priority over in_valid in the same cycle.
  - Reset asserted mid-stream discards any value presented that cycle.
- Counting:
  - Combinational sum of data[0]..data[WIDTH-1], built as a balanced adder tree of 1-bit then widening partial sums.
  - Any structure is fine if the result is exact for all 2^WIDTH inputs.
  - The result always fits in CW bits; no saturation or wrap is possible.
- Latency: 1 cycle. With in_valid=1 at edge N, count/is_zero/is_all reflect that data after edge N and out_valid=1 for the cycle following edge N.
- Hold: when in_valid=0 at an edge, count/is_zero/is_all hold their previous values and out_valid goes 0.
- Back-to-back: in_valid may be high every cycle. Each cycle's data produces a result one cycle later, with no bubbles and no backpressure (no ready signal).
- X-handling: data is sampled only when in_valid=1. X on data while in_valid=0 must not disturb outputs.
- Flag rules:
  - is_zero = (count_next == 0).
  - is_all = (count_next == WIDTH).
  - Both are evaluated on the same accepted data as count, so they are always mutually consistent with count.
- Default config truth table (WIDTH=3), data -> count:
  - 000->00, 001->01, 010->01, 011->10
  - 100->01, 101->10, 110->10, 111->11

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, data=3'b111 -> count=0, out_valid=0, is_zero=1, is_all=0 throughout.
- Exhaustive sweep (WIDTH=3): in_valid=1, data=0..7 on consecutive cycles -> one cycle later count=0,1,1,2,1,2,2,3 and out_valid=1 every cycle. is_zero=1 only for 000; is_all=1 only for 111.
- Hold: accept data=3'b101, then in_valid=0 with data=3'b000 for 3 cycles -> count stays 2, out_valid=1 for one cycle then 0.
- Reset mid-stream: streaming 3'b011 then 3'b111, drop rst_n=0 on the 3'b111 edge -> next cycle count=0, out_valid=0. After release, in_valid=1 data=3'b110 -> count=2.
- Wide config (WIDTH=8, CW=4): data=8'hFF -> count=8, is_all=1. data=8'h00 -> count=0, is_zero=1. data=8'hA5 -> count=4. data=8'h80 -> count=1.
- Random (WIDTH=3 and WIDTH=17): 1000 random data values with random in_valid -> count matches the reference popcount, delayed one accepted cycle.

Source files
------------

// File: rtl/number_of_1s_count.sv
// number_of_1s_count: registered population count with zero/all-ones flags.
//
// Interface semantics:
//   in_valid is a strobe with no ready/backpressure. Every cycle where
//   in_valid=1 at a rising edge is an accepted input. Exactly one cycle
//   later out_valid is high for one cycle and count/is_zero/is_all carry
//   the result for that input. When in_valid=0, data is ignored (it may
//   be X) and the result outputs hold their last values.
//
// All outputs are driven directly by flops. No combinational path runs from
// any input to any output.
module number_of_1s_count #(
    parameter  int WIDTH = 3,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count,
    output logic             out_valid,
    output logic             is_zero,
    output logic             is_all
);

    // The number of leaves is rounded up to a power of two so the adder tree
    // is fully balanced. Unused leaves are tied to zero.
    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int P      = 1 << LEVELS;

    // Count value that means every input bit was set.
    localparam logic [CW-1:0] ALL_COUNT = CW'(WIDTH);

    // Heap-ordered tree. Node n has children 2n and 2n+1, and node 1 is the
    // root. Leaves occupy P..2P-1. Every node is CW bits wide. A partial sum
    // can never exceed WIDTH, so no node overflows.
    logic [CW-1:0] tree [1:2*P-1];
    logic [CW-1:0] count_next;
    logic          zero_next;
    logic          all_next;

    // Balanced adder tree. Leaves are loaded first, then the internal nodes
    // are reduced from the deepest level upward.
    always_comb begin
        for (int n = 1; n < 2 * P; n++) begin
            tree[n] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            tree[P + i] = CW'(data[i]);
        end
        for (int n = P - 1; n >= 1; n--) begin
            tree[n] = tree[2 * n] + tree[2 * n + 1];
        end
        count_next = tree[1];
    end

    // The flags are derived from the same sum as count, so they always agree with it.
    always_comb begin
        zero_next = (count_next == '0);
        all_next  = (count_next == ALL_COUNT);
    end

    // Result registers. Reset wins over in_valid. The result holds while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            out_valid <= 1'b0;
            is_zero   <= 1'b1;
            is_all    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                count   <= count_next;
                is_zero <= zero_next;
                is_all  <= all_next;
            end
        end
    end

endmodule

// File: tb/tb_number_of_1s_count.sv
// Bench for number_of_1s_count. It drives three instances in parallel:
// WIDTH=3 (default), WIDTH=8 and WIDTH=17.
module tb_number_of_1s_count;

    localparam int W = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv [3];
    logic [2:0]  dat0;
    logic [7:0]  dat1;
    logic [16:0] dat2;

    logic [1:0] cnt0;
    logic [3:0] cnt1;
    logic [4:0] cnt2;
    logic       ov [3];
    logic       iz [3];
    logic       ia [3];

    number_of_1s_count #(.WIDTH(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .data(dat0),
        .count(cnt0), .out_valid(ov[0]), .is_zero(iz[0]), .is_all(ia[0])
    );
    number_of_1s_count #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .data(dat1),
        .count(cnt1), .out_valid(ov[1]), .is_zero(iz[1]), .is_all(ia[1])
    );
    number_of_1s_count #(.WIDTH(17)) u_w17 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .data(dat2),
        .count(cnt2), .out_valid(ov[2]), .is_zero(iz[2]), .is_all(ia[2])
    );

    logic [63:0] ac [3];
    assign ac[0] = 64'(cnt0);
    assign ac[1] = 64'(cnt1);
    assign ac[2] = 64'(cnt2);

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          wid [3] = '{3, 8, 17};
    int          mc  [3];
    logic        mv  [3];
    logic        mz  [3];
    logic        ma  [3];
    logic [W-1:0] exp_q [3][$];
    bit          started = 0;

    function automatic logic [63:0] data_of(input int k);
        case (k)
            0:       return 64'(dat0);
            1:       return 64'(dat1);
            default: return 64'(dat2);
        endcase
    endfunction

    // Model: the result is the popcount of the last accepted word. Reset clears it.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                mc[k] = 0; mv[k] = 1'b0; mz[k] = 1'b1; ma[k] = 1'b0;
                exp_q[k].delete();
            end else begin
                mv[k] = iv[k];
                if (iv[k]) begin
                    mc[k] = $countones(data_of(k));
                    mz[k] = (mc[k] == 0);
                    ma[k] = (mc[k] == wid[k]);
                    exp_q[k].push_back(W'(mc[k]));
                end
            end
        end
        started = 1;
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("w%0d_count", wid[k]), ac[k], 64'(mc[k]));
                check($sformatf("w%0d_out_valid", wid[k]), 64'(ov[k]), 64'(mv[k]));
                check($sformatf("w%0d_is_zero", wid[k]), 64'(iz[k]), 64'(mz[k]));
                check($sformatf("w%0d_is_all", wid[k]), 64'(ia[k]), 64'(ma[k]));
                if (ov[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("w%0d_unexpected_valid", wid[k]), 64'd1, 64'd0);
                    end else begin
                        check($sformatf("w%0d_stream", wid[k]), ac[k], 64'(exp_q[k].pop_front()));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs are changed 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        iv[0] = 1'b0; iv[1] = 1'b0; iv[2] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int sweep_exp [8] = '{0, 1, 1, 2, 1, 2, 2, 3};

    initial begin
        rst_n = 1'b0;
        iv[0] = 1'b1; iv[1] = 1'b1; iv[2] = 1'b1;
        dat0 = 3'b111; dat1 = 8'hFF; dat2 = '1;

        // Reset held for two edges with valid inputs present.
        tick();
        tick();
        check("rst_count", 64'(cnt0), 64'd0);
        check("rst_out_valid", 64'(ov[0]), 64'd0);
        check("rst_is_zero", 64'(iz[0]), 64'd1);
        check("rst_is_all", 64'(ia[0]), 64'd0);
        rst_n = 1'b1;
        idle_all();

        // Exhaustive sweep of WIDTH=3, back to back.
        for (int i = 0; i < 8; i++) begin
            iv[0] = 1'b1;
            dat0  = 3'(i);
            tick();
            check($sformatf("sweep_%0d_count", i), 64'(cnt0), 64'(sweep_exp[i]));
            check($sformatf("sweep_%0d_valid", i), 64'(ov[0]), 64'd1);
        end
        iv[0] = 1'b0;

        // Hold: accept 101, then idle with 000 (and X) on data.
        iv[0] = 1'b1; dat0 = 3'b101;
        tick();
        check("hold_accept", 64'(cnt0), 64'd2);
        iv[0] = 1'b0; dat0 = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) dat0 = 3'bxxx;
            tick();
            check($sformatf("hold_%0d_count", i), 64'(cnt0), 64'd2);
            check($sformatf("hold_%0d_valid", i), 64'(ov[0]), 64'd0);
        end

        // Reset arriving on the same edge as 111 discards that value.
        iv[0] = 1'b1; dat0 = 3'b011;
        tick();
        check("mid_pre", 64'(cnt0), 64'd2);
        dat0 = 3'b111; rst_n = 1'b0;
        tick();
        check("mid_rst_count", 64'(cnt0), 64'd0);
        check("mid_rst_valid", 64'(ov[0]), 64'd0);
        rst_n = 1'b1; dat0 = 3'b110;
        tick();
        check("mid_after", 64'(cnt0), 64'd2);
        iv[0] = 1'b0;

        // Wide configuration, WIDTH=8.
        iv[1] = 1'b1; dat1 = 8'hFF;
        tick();
        check("w8_ff_count", 64'(cnt1), 64'd8);
        check("w8_ff_all", 64'(ia[1]), 64'd1);
        dat1 = 8'h00;
        tick();
        check("w8_00_count", 64'(cnt1), 64'd0);
        check("w8_00_zero", 64'(iz[1]), 64'd1);
        dat1 = 8'hA5;
        tick();
        check("w8_a5_count", 64'(cnt1), 64'd4);
        dat1 = 8'h80;
        tick();
        check("w8_80_count", 64'(cnt1), 64'd1);
        iv[1] = 1'b0;

        // WIDTH=17 boundaries.
        iv[2] = 1'b1; dat2 = '1;
        tick();
        check("w17_all_count", 64'(cnt2), 64'd17);
        check("w17_all_flag", 64'(ia[2]), 64'd1);
        dat2 = 17'h10001;
        tick();
        check("w17_ends", 64'(cnt2), 64'd2);
        iv[2] = 1'b0;

        // Random traffic on all three instances at once.
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 3; k++) iv[k] = 1'($urandom_range(0, 1));
            dat0 = 3'($urandom_range(0, 7));
            dat1 = 8'($urandom_range(0, 255));
            dat2 = 17'($urandom_range(0, 131071));
            if ($urandom_range(0, 15) == 0) dat2 = '1;
            if ($urandom_range(0, 15) == 0) dat2 = '0;
            tick();
        end

        // Drain, then check that every accepted input produced an output.
        idle_all();
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("w%0d_drain", wid[k]), 64'(exp_q[k].size()), 64'd0);
        end

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
